// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full adder is reused for WIDTH cycles, LSB first,
// behind a start/done handshake. Subtract is A + ~B + 1 (inverted B, carry-in 1).

module FULL_ADDER (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);
  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SnA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
  output logic             CO,
  output logic             V,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic             co_q, co_d;
  logic             v_q, v_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;

  FULL_ADDER u_fa (
    .A  (a_sr_q[0]),
    .B  (b_sr_q[0]),
    .CI (carry_q),
    .S  (fa_s),
    .CO (fa_co)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    r_sr_d    = r_sr_q;
    r_d       = r_q;
    carry_d   = carry_q;
    cin_msb_d = cin_msb_q;
    co_d      = co_q;
    v_d       = v_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_RUN;
          a_sr_d  = A;
          b_sr_d  = B ^ {WIDTH{SnA}};
          carry_d = SnA;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        r_sr_d  = {fa_s, r_sr_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        // MSB step: overflow compares the carry into the MSB with the carry out of it
        if (cnt_q == CW'(WIDTH - 1)) begin
          cin_msb_d = carry_q;
          state_d   = S_DONE;
          r_d       = {fa_s, r_sr_q[WIDTH-1:1]};
          co_d      = fa_co;
          v_d       = cin_msb_d ^ fa_co;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      r_sr_q    <= '0;
      r_q       <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      co_q      <= 1'b0;
      v_q       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      r_sr_q    <= r_sr_d;
      r_q       <= r_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
      co_q      <= co_d;
      v_q       <= v_d;
      cnt_q     <= cnt_d;
    end
  end

  assign R    = r_q;
  assign CO   = co_q;
  assign V    = v_q;
  assign BUSY = (state_q == S_RUN) || (state_q == S_DONE);
  assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: expected results are queued at accept
// and compared when DONE pulses; handshake timing is checked cycle by cycle.

module tb_serial_addsub_ctrl;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         v;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic         SnA = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] R;
  logic         CO, V, BUSY, DONE;

  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  exp_t exp_q[$];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .SnA  (SnA),
    .A    (A),
    .B    (B),
    .R    (R),
    .CO   (CO),
    .V    (V),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic sna, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] s;
    if (sna) s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     s = {1'b0, a} + {1'b0, b};
    e.r  = s[W-1:0];
    e.co = s[W];
    if (sna) e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    else     e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    return e;
  endfunction

  // Result monitor: every DONE pulse consumes one scoreboard entry.
  always @(negedge CLK) begin
    if (DONE) begin
      done_cnt++;
      chk("done_width", 64'(prev_done), 64'd0);
      chk("sb_empty", 64'(exp_q.size() == 0), 64'd0);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("R", 64'(R), 64'(e.r));
        chk("CO", 64'(CO), 64'(e.co));
        chk("V", 64'(V), 64'(e.v));
      end
    end
    prev_done = DONE;
  end

  // mode 0: plain op, 1: extra START at E10 (ignored), 2: reset at E10
  task automatic do_op(input logic sna, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int mode);
    int d0;
    @(negedge CLK);
    START = 1'b1; SnA = sna; A = a; B = b;
    @(posedge CLK);
    if (mode != 2) exp_q.push_back(model(sna, a, b));
    d0 = done_cnt;
    @(negedge CLK);
    START = 1'b0; A = $urandom; B = $urandom; SnA = ~sna;
    chk("busy_e0", 64'(BUSY), 64'd1);
    chk("done_e0", 64'(DONE), 64'd0);
    for (int i = 1; i <= W; i++) begin
      if (i == 10 && mode == 1) begin
        START = 1'b1; A = 32'h1234_5678; B = 32'h0FED_CBA9;
      end
      if (i == 10 && mode == 2) RST = 1'b1;
      @(negedge CLK);
      if (mode == 1 && i == 10) START = 1'b0;
      if (mode == 2 && i == 10) begin
        RST = 1'b0;
        chk("rst_R", 64'(R), 64'd0);
        chk("rst_CO", 64'(CO), 64'd0);
        chk("rst_V", 64'(V), 64'd0);
        chk("rst_BUSY", 64'(BUSY), 64'd0);
        chk("rst_DONE", 64'(DONE), 64'd0);
        break;
      end
      chk("busy_run", 64'(BUSY), 64'd1);
      chk("done_time", 64'(DONE), 64'(i == W));
    end
    if (mode == 2) begin
      for (int k = 0; k < W + 4; k++) begin
        @(negedge CLK);
        chk("no_done_after_rst", 64'(DONE), 64'd0);
      end
      chk("done_cnt_rst", 64'(done_cnt - d0), 64'd0);
    end else begin
      @(negedge CLK);
      chk("busy_idle", 64'(BUSY), 64'd0);
      chk("done_idle", 64'(DONE), 64'd0);
      chk("one_done", 64'(done_cnt - d0), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_R", 64'(R), 64'd0);
    chk("reset_CO", 64'(CO), 64'd0);
    chk("reset_V", 64'(V), 64'd0);
    chk("reset_BUSY", 64'(BUSY), 64'd0);
    chk("reset_DONE", 64'(DONE), 64'd0);
    RST = 1'b0;

    do_op(1'b0, 32'd5, 32'd3, 0);
    do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(1'b1, 32'd3, 32'd5, 0);
    do_op(1'b1, 32'h8000_0000, 32'h0000_0001, 0);
    do_op(1'b1, 32'h89AB_CDEF, 32'h1357_9BDF, 1);
    do_op(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 2);
    do_op(1'b0, 32'h0000_1111, 32'h0000_2222, 0);
    for (int n = 0; n < 4; n++)
      do_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 0);

    // START held high: accepts at E0, E34, E68
    @(negedge CLK);
    START = 1'b1; SnA = 1'b0; A = 32'd1; B = 32'd1;
    for (int n = 0; n < 3; n++) exp_q.push_back(model(1'b0, 32'd1, 32'd1));
    for (int i = 0; i <= 101; i++) begin
      @(negedge CLK);
      chk("held_done", 64'(DONE), 64'((i == 32) || (i == 66) || (i == 100)));
      chk("held_busy", 64'(BUSY), 64'((i % 34) != 33));
      if (i >= 32) chk("held_R_stable", 64'(R), 64'd2);
    end
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
